pwm_ramp_ctrl: RTL and testbench
================================

PWM_RAMP_CTRL -- requirements
Module: pwm_ramp_ctrl

Interface
REQ-001 SHALL have parameter PERIOD_CYCLES, default 257, giving clock cycles per PWM period (range 2..65535).
REQ-002 SHALL have parameter STEP_PERIODS, default 4, giving PWM periods per duty step (range 1..255).
REQ-003 SHALL have port CLK  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port TGT_DUTY  input  8  requested final duty value.
REQ-006 SHALL have port TGT_STEP  input  8  duty change per step; 0 is treated as 1.
REQ-007 SHALL have port TGT_VALID  input  1  request valid.
REQ-008 SHALL have port TGT_READY  output  1  request can be accepted.
REQ-009 SHALL have port DUTY  output  8  current duty, registered, drives the PWM generator's duty input.
REQ-010 SHALL have port DUTY_LD  output  1  one-cycle pulse, high in the first cycle DUTY shows a new value.
REQ-011 SHALL have port BUSY  output  1  high while a ramp is in progress.
REQ-012 SHALL have port DONE  output  1  one-cycle pulse when DUTY reaches the target.

Function
REQ-013 SHALL run a free-running period counter 0..PERIOD_CYCLES-1 that wraps to 0. A period tick occurs in the cycle where the count equals PERIOD_CYCLES-1.
REQ-014 SHALL keep a step counter 0..STEP_PERIODS-1 that advances on each period tick. A step event occurs on a period tick when the step counter equals STEP_PERIODS-1. The counter then wraps to 0.
REQ-015 SHALL implement states IDLE, RAMP and FIN.
REQ-016 IDLE: TGT_READY=1, BUSY=0. On TGT_VALID&TGT_READY:
  - latch TGT_DUTY and the effective step (max(TGT_STEP,1));
  - clear the step counter; the period counter is not cleared;
  - go to FIN if the latched target equals DUTY, otherwise go to RAMP.
REQ-017 RAMP: TGT_READY=0, BUSY=1. TGT_VALID is ignored. On each step event, with diff = |target-DUTY| computed in 9 bits:
  - if diff <= step, DUTY <= target and go to FIN;
  - else DUTY <= DUTY+step when target > DUTY, or DUTY-step when target < DUTY.
REQ-018 DUTY SHALL never wrap past 0 or 255. The clamp of REQ-017 guarantees this.
REQ-019 FIN: DONE=1, BUSY=0, TGT_READY=0 for exactly one cycle, then go to IDLE.
REQ-020 DUTY_LD SHALL be high only in the cycle after a DUTY register update. It SHALL NOT pulse when target equals DUTY at acceptance.
REQ-021 The first step SHALL occur STEP_PERIODS-1 full periods plus 1..PERIOD_CYCLES cycles after acceptance. Later steps SHALL be spaced exactly STEP_PERIODS*PERIOD_CYCLES cycles apart.
REQ-022 TGT_READY, BUSY and DONE SHALL be decoded from the state register only, with no combinational path from inputs.

Reset
REQ-023 RST high SHALL, immediately and independent of CLK, force:
  - state=IDLE, DUTY=0, DUTY_LD=0, DONE=0, BUSY=0;
  - period and step counters = 0, latched target = 0, latched step = 1.
REQ-024 While RST is high, TGT_READY SHALL read 1 (IDLE decode), but no request SHALL be accepted until the first rising edge after RST falls.
REQ-025 RST asserted mid-ramp SHALL abandon the ramp with no DONE pulse.

Verification (PERIOD_CYCLES=4, STEP_PERIODS=2, so steps are 8 cycles apart)
REQ-026 Up ramp: DUTY=0, request target 10 step 4 -> DUTY 4,8,10, three DUTY_LD pulses, DONE one cycle after DUTY=10, BUSY high throughout the ramp.
REQ-027 Down ramp: DUTY=10, request target 1 step 3 -> DUTY 7,4,1, DONE once, then TGT_READY=1.
REQ-028 Zero step and equal target:
  - target 3 step 0 from DUTY=0 -> DUTY 1,2,3;
  - then request target 3 -> FIN next cycle, DONE pulse, no DUTY_LD.
REQ-029 Extremes: DUTY=0, target 255 step 255 -> single step to 255. Then target 0 step 200 -> 55, then 0. No wrap observed.
REQ-030 Ignored request and mid-ramp reset:
  - TGT_VALID toggled during RAMP with target 50 -> no effect;
  - RST pulsed mid-ramp (DUTY=8) -> DUTY=0, BUSY=0, no DONE, TGT_READY=1 after release.

Source files
------------

// File: rtl/pwm_ramp_ctrl.sv
// Duty-cycle ramp controller: walks DUTY toward a requested target in fixed
// steps, one step every STEP_PERIODS PWM periods, without wrapping past 0/255.
module pwm_ramp_ctrl #(
   parameter int PERIOD_CYCLES = 257,
   parameter int STEP_PERIODS  = 4
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [7:0] TGT_DUTY,
   input  logic [7:0] TGT_STEP,
   input  logic       TGT_VALID,
   output logic       TGT_READY,
   output logic [7:0] DUTY,
   output logic       DUTY_LD,
   output logic       BUSY,
   output logic       DONE
);

   localparam int PW = (PERIOD_CYCLES > 2) ? $clog2(PERIOD_CYCLES) : 1;
   localparam int SW = (STEP_PERIODS  > 2) ? $clog2(STEP_PERIODS)  : 1;
   localparam logic [PW-1:0] PMAX = PW'(PERIOD_CYCLES - 1);
   localparam logic [SW-1:0] SMAX = SW'(STEP_PERIODS - 1);

   typedef enum logic [1:0] {IDLE, RAMP, FIN} state_t;

   state_t        state, state_nxt;
   logic [PW-1:0] pcnt;
   logic [SW-1:0] scnt;
   logic [7:0]    duty_q, tgt_q, step_q;
   logic          ld_q;
   logic          tick, step_ev, accept, reach, up;
   logic [8:0]    diff;

   assign tick    = (pcnt == PMAX);
   assign step_ev = tick && (scnt == SMAX);
   assign accept  = TGT_VALID && (state == IDLE);
   assign up      = (tgt_q > duty_q);
   assign diff    = up ? ({1'b0, tgt_q} - {1'b0, duty_q}) : ({1'b0, duty_q} - {1'b0, tgt_q});
   // Landing exactly on the target whenever it is within one step is what keeps DUTY in range.
   assign reach   = (diff <= {1'b0, step_q});

   // Handshake/status decode purely from state so there is no input-to-output path.
   assign TGT_READY = (state == IDLE);
   assign BUSY      = (state == RAMP);
   assign DONE      = (state == FIN);
   assign DUTY      = duty_q;
   assign DUTY_LD   = ld_q;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (TGT_VALID) state_nxt = (TGT_DUTY == duty_q) ? FIN : RAMP;
         RAMP:    if (step_ev && reach) state_nxt = FIN;
         FIN:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         pcnt   <= '0;
         scnt   <= '0;
         duty_q <= 8'd0;
         tgt_q  <= 8'd0;
         step_q <= 8'd1;
         ld_q   <= 1'b0;
      end else begin
         pcnt <= tick ? '0 : pcnt + PW'(1);
         // Acceptance restarts the step phase but leaves the PWM period alone.
         if (accept)    scnt <= '0;
         else if (tick) scnt <= (scnt == SMAX) ? '0 : scnt + SW'(1);
         if (accept) begin
            tgt_q  <= TGT_DUTY;
            step_q <= (TGT_STEP == 8'd0) ? 8'd1 : TGT_STEP;
         end
         ld_q <= 1'b0;
         if (state == RAMP && step_ev) begin
            ld_q <= 1'b1;
            if (reach)   duty_q <= tgt_q;
            else if (up) duty_q <= duty_q + step_q;
            else         duty_q <= duty_q - step_q;
         end
      end
   end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Scoreboard bench for pwm_ramp_ctrl: a request-level model predicts the edge
// of every DUTY update and DONE pulse; a negedge monitor checks them cycle by cycle.
`timescale 1ns/1ps
module tb_pwm_ramp_ctrl;
   localparam int P = 4;
   localparam int S = 2;

   logic       CLK = 1'b0, RST = 1'b0;
   logic [7:0] TGT_DUTY = 8'd0, TGT_STEP = 8'd0;
   logic       TGT_VALID = 1'b0;
   logic       TGT_READY, DUTY_LD, BUSY, DONE;
   logic [7:0] DUTY;

   pwm_ramp_ctrl #(.PERIOD_CYCLES(P), .STEP_PERIODS(S)) dut (
      .CLK(CLK), .RST(RST), .TGT_DUTY(TGT_DUTY), .TGT_STEP(TGT_STEP),
      .TGT_VALID(TGT_VALID), .TGT_READY(TGT_READY), .DUTY(DUTY),
      .DUTY_LD(DUTY_LD), .BUSY(BUSY), .DONE(DONE));

   always #5 CLK = ~CLK;

   typedef struct {int ecyc; bit is_done; int val;} exp_t;
   exp_t sbq[$];

   // n = number of rising edges since reset release; ramp lives in edges [ma, mf), FIN at mf.
   int n = 0, ma = -1, mf = -1, mduty = 0, cur = 0, last_e1 = 0;
   int checks = 0, errors = 0;

   always @(posedge CLK) begin
      if (RST) n <= 0;
      else     n <= n + 1;
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (edge %0d, t=%0t)", nm, got, exp, n, $time);
      end
   endtask

   always @(negedge CLK) begin
      bit ld_exp, dn_exp, ramp, fin;
      exp_t e;
      ld_exp = 0; dn_exp = 0;
      if (RST) cur = 0;
      while (!RST && sbq.size() > 0 && sbq[0].ecyc <= n) begin
         e = sbq.pop_front();
         if (e.ecyc != n) chk("sb_edge", e.ecyc, n);
         else if (e.is_done) dn_exp = 1;
         else begin ld_exp = 1; cur = e.val; end
      end
      ramp = !RST && (n >= ma) && (n < mf);
      fin  = !RST && (n == mf);
      chk("duty_ld", DUTY_LD, ld_exp);
      chk("done", DONE, dn_exp);
      chk("duty", DUTY, cur);
      chk("busy", BUSY, ramp);
      chk("ready", TGT_READY, !ramp && !fin);
   end

   // Issue one request once the model says the block is idle, and predict its outcome.
   task automatic req(input int t, input int s, input int gap);
      int w, a, e, d, st, f, diff;
      @(negedge CLK);
      w = 0;
      while (n <= mf && w < 4000) begin @(negedge CLK); w++; end
      if (w >= 4000) begin chk("idle_timeout", 0, 1); return; end
      repeat (gap) @(negedge CLK);
      a = n + 1;
      TGT_DUTY = 8'(t); TGT_STEP = 8'(s); TGT_VALID = 1'b1;
      d = mduty;
      st = (s == 0) ? 1 : s;
      if (t == d) begin
         sbq.push_back('{a, 1'b1, 0});
         f = a;
      end else begin
         e = ((a / P) + 1) * P + (S - 1) * P;
         last_e1 = e;
         f = e;
         while (1) begin
            diff = (t > d) ? t - d : d - t;
            if (diff <= st) begin
               d = t;
               sbq.push_back('{e, 1'b0, d});
               sbq.push_back('{e, 1'b1, 0});
               f = e;
               break;
            end
            d = (t > d) ? d + st : d - st;
            sbq.push_back('{e, 1'b0, d});
            e += S * P;
         end
      end
      mduty = d; ma = a; mf = f;
      @(negedge CLK);
      TGT_VALID = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge CLK);
      #2;
      RST = 1'b1;
      sbq.delete();
      ma = -1; mf = -1; mduty = 0;
      #1;
      chk("rst_duty", DUTY, 0);
      chk("rst_busy", BUSY, 0);
      chk("rst_done", DONE, 0);
      chk("rst_ld", DUTY_LD, 0);
      chk("rst_ready", TGT_READY, 1);
      repeat (3) @(posedge CLK);
      #2;
      RST = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got %0d checks", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int t, s, w;
      do_reset();
      req(10, 4, 2);       // up ramp 4,8,10
      req(1, 3, 1);        // down ramp 7,4,1
      req(0, 5, 0);
      req(3, 0, 3);        // zero step -> 1,2,3
      req(3, 9, 0);        // equal target: DONE only
      req(0, 255, 1);
      req(255, 255, 0);    // single step to 255
      req(0, 200, 2);      // 55 then 0
      repeat (24) begin
         t = $urandom_range(0, 255);
         s = $urandom_range(4, 80);
         if ($urandom_range(0, 5) == 0) begin
            s = 0;
            t = mduty + $urandom_range(0, 12) - 6;
            if (t < 0) t = 0;
            if (t > 255) t = 255;
         end
         if ($urandom_range(0, 7) == 0) t = mduty;
         req(t, s, $urandom_range(0, 5));
      end
      // Ignored request mid-ramp, then reset once DUTY has reached 8.
      req(0, 255, 0);
      req(50, 4, 1);
      for (int k = 0; k < 6; k++) begin
         @(negedge CLK);
         TGT_DUTY = 8'd50; TGT_STEP = 8'd1; TGT_VALID = ~TGT_VALID;
      end
      TGT_VALID = 1'b0;
      w = 0;
      while (n < last_e1 + S * P && w < 200) begin @(negedge CLK); w++; end
      if (w >= 200) chk("mid_wait_timeout", 0, 1);
      chk("mid_duty_before_rst", DUTY, 8);
      do_reset();
      repeat (20) @(negedge CLK);
      req(6, 2, 0);
      @(negedge CLK);
      w = 0;
      while (n <= mf && w < 4000) begin @(negedge CLK); w++; end
      if (w >= 4000) chk("final_timeout", 0, 1);
      repeat (3) @(negedge CLK);
      chk("sb_empty", sbq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
